// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for the pipe_stage_reg pipeline stage: FSM state values
// (which double as the occupancy count) and the all-zero bubble payload.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] ZERO_PAYLOAD = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones,
// returns to zero on clear or synchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: assign a default to every always_comb output first; a path that skips it infers a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with optional skid entry (build with PIPE_STAGE_SKID_EN
// for the two-entry version with a registered in_ready), flush and a stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_PAYLOAD);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  assign in_ready = ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (pop && !push) begin
          state_d = EMPTY;
          main_d  = ZERO_DATA;
        end else if (push && pop) begin
          main_d = in_data;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = ZERO_DATA;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = ZERO_DATA;
        skid_d  = ZERO_DATA;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = ZERO_DATA;
      skid_d  = ZERO_DATA;
    end
    // Registered ready looks at the next state, so it never depends on out_ready this cycle.
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_q <= ZERO_DATA;
    end else begin
      skid_q <= skid_d;
    end
  end
`else
  // Single entry: accept when empty or when the held payload leaves this cycle.
  assign in_ready = ready_q & (~out_valid | out_ready);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      default: begin
        if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
          main_d  = ZERO_DATA;
        end
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = ZERO_DATA;
    end
    ready_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      // NOTE: the payload register is reset on purpose: an empty stage must present an all-zero bubble.
      main_q  <= ZERO_DATA;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      ready_q <= ready_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the stage payload bundle (opcode/func/operands/dest fields).
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 flush  input  1  kill all held entries (branch/exception redirect).
REQ-006 in_valid  input  1  upstream holds a valid payload.
REQ-007 in_ready  output  1  stage accepts a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid payload.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  DATA_W  payload presented downstream.
REQ-012 occupancy  output  2  number of held entries (0..2).
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated in the same cycle.
REQ-015 Latency: a payload pushed in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when the stage was empty.
REQ-016 Storage: main register (drives out_data) plus skid register; order is strictly FIFO.
REQ-017 States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2); out_valid=1 in ONE and TWO; occupancy encodes the state.
REQ-018 EMPTY: push -> ONE, main<=in_data; otherwise stay.
REQ-019 ONE: push&!pop -> TWO, skid<=in_data; pop&!push -> EMPTY; push&pop -> ONE, main<=in_data; neither -> stay.
REQ-020 TWO: pop -> ONE, main<=skid; no pop -> stay; push is impossible because in_ready=0.
REQ-021 in_ready SHALL be a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-022 In EMPTY, and after flush, main and skid SHALL hold all-zero data, so that out_data=0 (bubble).
REQ-023 flush=1 SHALL force next state EMPTY and zero both registers; it overrides any push or pop in the same cycle, and the pushed payload is dropped.
REQ-024 A pop in a flush cycle still counts as consumed by downstream; the stage does not re-present that payload.
REQ-025 stall_cnt SHALL increment each cycle with out_valid & !out_ready, saturate at all-ones, and be unaffected by flush.
REQ-026 Data SHALL never be lost or duplicated under any push/pop/out_ready pattern without flush.

Reset
REQ-027 While rst=0 at a clock edge: state EMPTY, main=0, skid=0, out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
REQ-028 in_ready SHALL be 0 during reset and 1 on the first cycle after rst is released.
REQ-029 A reset asserted mid-operation SHALL discard all held entries with no further output.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: two-entry skid behaviour as in REQ-016 to REQ-021.
REQ-031 PIPE_STAGE_SKID_EN undefined: no skid register; states EMPTY and ONE only; occupancy max 1.
REQ-032 In that case in_ready = !out_valid | out_ready, combinationally; all other rules are unchanged.

Structure
REQ-033 A shared package SHALL hold the state encoding constants (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and ZERO_PAYLOAD.
REQ-034 The stall counter SHALL be one sub-module, sat_counter (parameter CNT_W; inputs inc and clear).
REQ-035 The FSM and data registers stay in pipe_stage_reg.

Verification
REQ-036 Reset release, in_valid=1, in_data=0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 the next cycle, occupancy=1.
REQ-037 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0.
REQ-038 Continuing REQ-037, out_ready=1 for 2 cycles -> out_data 0x11 then 0x22, then EMPTY with out_data=0; stall_cnt counts the held cycles.
REQ-039 Stage in TWO, flush=1 with in_valid=1 and in_data=0x33 -> next cycle EMPTY, out_valid=0, out_data=0, 0x33 never emitted.
REQ-040 Hold out_ready=0 for 2^CNT_W+5 cycles with out_valid=1 -> stall_cnt saturates at all-ones.
REQ-041 Random in_valid/out_ready with an incrementing payload and no flush -> output sequence equals input sequence.
REQ-042 Repeat REQ-041 with PIPE_STAGE_SKID_EN defined and with it undefined.
